// File: rtl/bf16_fp8_packer.sv
// bf16_fp8_packer
//   Converts a stream of BF16 accumulator values to FP8 E4M3 bytes and packs
//   them four to a 32-bit word. The conversion rounds to nearest even. Values
//   that are too large saturate to +/-448, and values that are too small
//   flush to zero. There are no FP8 subnormals.
//   The pipeline has two stages: an S1 register holding the converted byte,
//   and a pack stage that feeds the output word register. The latency is two
//   cycles.
//
// Ports
//   clk, rst            sole clock, synchronous active-high reset
//   clear               zeroes sat_count / uf_count (wins over an increment)
//   in_valid/in_ready   input handshake; in_data = BF16, in_last = end of tile
//   out_valid/out_ready output handshake; out_data = 4 FP8 bytes (lane 0 in
//                       [7:0]), out_keep = valid lanes, out_last = tile end
//   sat_count, uf_count saturating event counters (saturation / underflow)
module bf16_fp8_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic [15:0] sat_count,
    output logic [15:0] uf_count
);
    localparam int NUM_LANES = 4;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } s1_t;

    // ---------------- conversion (combinational, on in_data) ----------------
    logic       cv_sign;
    logic [7:0] cv_exp;
    logic [6:0] cv_man;
    logic       cv_inc;
    logic [3:0] cv_sum;
    logic [2:0] cv_mant;
    logic [9:0] cv_ef;      // two's complement; e spans 1..254, so no wrap
    logic [7:0] cv_byte;
    logic       cv_sat;
    logic       cv_uf;

    always_comb begin
        cv_sign = in_data[15];
        cv_exp  = in_data[14:7];
        cv_man  = in_data[6:0];
        // RNE: guard = m[3], sticky = |m[2:0], lsb = m[4]
        cv_inc  = cv_man[3] & ((|cv_man[2:0]) | cv_man[4]);
        cv_sum  = {1'b0, cv_man[6:4]} + {3'b000, cv_inc};
        cv_mant = cv_sum[3] ? 3'b000 : cv_sum[2:0];
        cv_ef   = {2'b00, cv_exp} + {9'd0, cv_sum[3]} - 10'd120;
        cv_byte = 8'h00;
        cv_sat  = 1'b0;
        cv_uf   = 1'b0;
        if (cv_exp == 8'hFF) begin
            cv_byte = {cv_sign, 7'h7E};
            cv_sat  = 1'b1;
        end else if (cv_exp != 8'h00) begin
            if (!cv_ef[9] && ((cv_ef > 10'd15) ||
                              (cv_ef == 10'd15 && cv_mant == 3'b111))) begin
                // 0x7F/0xFF would be NaN in E4M3, so clamp to 448
                cv_byte = {cv_sign, 7'h7E};
                cv_sat  = 1'b1;
            end else if (cv_ef[9] || cv_ef == 10'd0) begin
                cv_uf   = 1'b1;
            end else begin
                cv_byte = {cv_sign, cv_ef[3:0], cv_mant};
            end
        end
    end

    // ---------------- handshake / pipeline control ----------------
    s1_t                        s1_q;
    logic                       s1_valid;
    logic [1:0]                 lane;
    logic [2:0][7:0]            part;
    logic                       completes;
    logic                       s1_adv;
    logic                       in_fire;
    logic [NUM_LANES-1:0][7:0]  word_next;
    logic [NUM_LANES-1:0]       keep_next;

    assign completes = (lane == 2'd3) | s1_q.last;
    // A non-completing byte only lands in the partial store, so it never
    // waits on the output register.
    assign s1_adv    = s1_valid & (~completes | ~out_valid | out_ready);
    assign in_ready  = ~s1_valid | s1_adv;
    assign in_fire   = in_valid & in_ready;

    // Lanes below the counter come from the partial store. The current lane
    // comes from S1. Lanes above it are zero, so stale partial bytes never
    // leak into a short word.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        if (i < NUM_LANES - 1) begin : g_low
            assign word_next[i] = (2'(i) < lane)  ? part[i]   :
                                  (2'(i) == lane) ? s1_q.data : 8'h00;
        end else begin : g_top
            assign word_next[i] = (lane == 2'd3) ? s1_q.data : 8'h00;
        end
    end
    assign keep_next = 4'b1111 >> (2'd3 - lane);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            lane      <= 2'd0;
            part      <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_keep  <= 4'h0;
            out_last  <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid  <= 1'b1;
                s1_q.last <= in_last;
                s1_q.data <= cv_byte;
            end else if (s1_adv) begin
                s1_valid  <= 1'b0;
            end

            if (s1_adv) begin
                if (completes) begin
                    lane <= 2'd0;
                end else begin
                    lane <= lane + 2'd1;
                end
            end

            for (int i = 0; i < NUM_LANES - 1; i++) begin
                if (s1_adv && !completes && lane == 2'(i)) begin
                    part[i] <= s1_q.data;
                end
            end

            if (s1_adv && completes) begin
                out_valid <= 1'b1;
                out_data  <= word_next;
                out_keep  <= keep_next;
                out_last  <= s1_q.last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // ---------------- statistics ----------------
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sat_count <= 16'h0;
            uf_count  <= 16'h0;
        end else begin
            if (in_fire && cv_sat && sat_count != 16'hFFFF) begin
                sat_count <= sat_count + 16'd1;
            end
            if (in_fire && cv_uf && uf_count != 16'hFFFF) begin
                uf_count <= uf_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bf16_fp8_packer.sv
// Testbench for bf16_fp8_packer: directed conversion/packing/backpressure/reset
// cases plus a randomized phase. A negedge monitor pushes expected words from
// an arithmetic reference model and pops/compares on every output transfer.
module tb_bf16_fp8_packer;
    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [15:0] sat_count;
    logic [15:0] uf_count;

    bf16_fp8_packer dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .sat_count(sat_count), .uf_count(uf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } exp_t;

    exp_t        expq[$];
    logic [7:0]  pbytes[$];
    logic [15:0] m_sat = 16'h0;
    logic [15:0] m_uf  = 16'h0;
    int          checks = 0;
    int          errors = 0;
    int          words_out = 0;
    bit          hold = 1'b0;
    logic [36:0] hold_val;

    // Reference: value = sig * 2^(e-134) with sig = 128+m. The FP8 significand
    // is sig/16 rounded half-to-even. It lies in [8,16], and reaching 16 renormalises.
    function automatic void ref_conv(input logic [15:0] x, output logic [7:0] b,
                                     output bit sat, output bit uf);
        int e, sig, q, r, ex;
        e   = int'(x[14:7]);
        sig = 128 + int'(x[6:0]);
        sat = 1'b0;
        uf  = 1'b0;
        b   = 8'h00;
        if (e == 255) begin
            b = {x[15], 7'h7E};
            sat = 1'b1;
        end else if (e != 0) begin
            q = sig / 16;
            r = sig % 16;
            if (r > 8 || (r == 8 && (q % 2) == 1)) q++;
            ex = e - 120;
            if (q == 16) begin q = 8; ex++; end
            if (ex > 15 || (ex == 15 && q == 15)) begin
                b = {x[15], 7'h7E};
                sat = 1'b1;
            end else if (ex <= 0) begin
                uf = 1'b1;
            end else begin
                b = {x[15], 4'(ex), 3'(q - 8)};
            end
        end
    endfunction

    function automatic logic [15:0] rnd_bf16();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 5))
            0, 1, 2: x[14:7] = 8'($urandom_range(114, 138));
            3:       x[14:7] = 8'h00;
            4:       x[14:7] = 8'hFF;
            default: ;
        endcase
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard / monitor, sampling half a cycle away from the active edge.
    always @(negedge clk) begin : mon
        bit         acc, sv, uv;
        logic [7:0] b;
        exp_t       e;
        if (rst) begin
            expq.delete();
            pbytes.delete();
            m_sat = 16'h0;
            m_uf  = 16'h0;
            hold  = 1'b0;
        end else begin
            checks++;
            if (sat_count !== m_sat || uf_count !== m_uf) begin
                errors++;
                $display("FAIL counters: got sat %0d uf %0d expected sat %0d uf %0d",
                         sat_count, uf_count, m_sat, m_uf);
            end
            if (hold) begin
                checks++;
                if (!out_valid || {out_data, out_keep, out_last} !== hold_val) begin
                    errors++;
                    $display("FAIL hold_stable: got v%0b 0x%0h expected 0x%0h",
                             out_valid, {out_data, out_keep, out_last}, hold_val);
                end
            end
            hold     = out_valid && !out_ready;
            hold_val = {out_data, out_keep, out_last};
            if (out_valid && out_ready) begin
                words_out++;
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got 0x%0h keep %0h, nothing expected",
                             out_data, out_keep);
                end else begin
                    e = expq.pop_front();
                    if (out_data !== e.d || out_keep !== e.k || out_last !== e.l) begin
                        errors++;
                        $display("FAIL word: got 0x%0h keep %0h last %0b expected 0x%0h keep %0h last %0b",
                                 out_data, out_keep, out_last, e.d, e.k, e.l);
                    end
                end
            end
            acc = in_valid && in_ready;
            sv = 1'b0;
            uv = 1'b0;
            if (acc) begin
                ref_conv(in_data, b, sv, uv);
                pbytes.push_back(b);
                if (pbytes.size() == 4 || in_last) begin
                    e.d = 32'h0;
                    for (int i = 0; i < pbytes.size(); i++) e.d[i*8 +: 8] = pbytes[i];
                    e.k = 4'((1 << pbytes.size()) - 1);
                    e.l = in_last;
                    expq.push_back(e);
                    pbytes.delete();
                end
            end
            if (clear) begin
                m_sat = 16'h0;
                m_uf  = 16'h0;
            end else begin
                if (sv && m_sat != 16'hFFFF) m_sat++;
                if (uv && m_uf != 16'hFFFF) m_uf++;
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic single(input logic [15:0] d, input logic [7:0] e, input string name);
        send(d, 1'b1);
        @(negedge clk);
        check({name, "_t1_idle"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({name, "_t2_valid"}, 32'(out_valid), 32'd1);
        check(name, out_data, {24'h0, e});
        check({name, "_keep"}, 32'(out_keep), 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [15:0] bp[9];
    logic [36:0] first_word;
    bit          got_first;
    bit          acc2;
    int          k, target;

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 16'h0; in_last = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_keep", 32'(out_keep), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_sat", 32'(sat_count), 32'h0);
        check("rst_uf", 32'(uf_count), 32'h0);
        @(posedge clk); #1;

        // Conversion corner cases, one value per word.
        single(16'h3F80, 8'h38, "cv_one");
        single(16'h4040, 8'h44, "cv_three");
        single(16'h3F88, 8'h38, "cv_tie_even");
        single(16'h3F98, 8'h3A, "cv_tie_up");
        single(16'h3C7F, 8'h08, "cv_carry_min");
        single(16'h0000, 8'h00, "cv_zero");
        check("cv_sat_cnt", 32'(sat_count), 32'd0);
        check("cv_uf_cnt", 32'(uf_count), 32'd0);

        // Saturation and underflow.
        single(16'h43F0, 8'h7E, "sat_pos");
        single(16'hC480, 8'hFE, "sat_neg");
        check("sat_cnt_2", 32'(sat_count), 32'd2);
        single(16'h7F80, 8'h7E, "sat_inf");
        check("sat_cnt_3", 32'(sat_count), 32'd3);
        single(16'h3B80, 8'h00, "uf_small");
        single(16'h3C00, 8'h00, "uf_ef0");
        check("uf_cnt_2", 32'(uf_count), 32'd2);
        pulse_clear();
        check("clear_sat", 32'(sat_count), 32'd0);
        check("clear_uf", 32'(uf_count), 32'd0);

        // Full word.
        send(16'h3F80, 1'b0);
        send(16'h4040, 1'b0);
        send(16'h3F98, 1'b0);
        send(16'hC480, 1'b1);
        @(negedge clk);
        check("pack_t1_idle", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("pack_valid", 32'(out_valid), 32'd1);
        check("pack_data", out_data, 32'hFE3A4438);
        check("pack_keep", 32'(out_keep), 32'hF);
        check("pack_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;

        // Partial word.
        send(16'h3F80, 1'b0);
        send(16'h4040, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("part_data", out_data, 32'h00004438);
        check("part_keep", 32'(out_keep), 32'h3);
        check("part_last", 32'(out_last), 32'd1);
        @(posedge clk); #1;

        // Backpressure: 8 values fit (S1 + 3 partial + output word).
        for (int i = 0; i < 9; i++) bp[i] = rnd_bf16();
        out_ready = 1'b0;
        k = 0;
        got_first = 1'b0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = bp[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready) k++;
            if (out_valid && !got_first) begin
                got_first  = 1'b1;
                first_word = {out_data, out_keep, out_last};
            end
            @(posedge clk); #1;
            if (k < 9) in_data = bp[k];
        end
        @(negedge clk);
        check("bp_accepted", 32'(k), 32'd8);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_held", {27'h0, 1'b0, out_valid, out_keep} & 32'h1F, {27'h0, 1'b0, 1'b1, 4'hF});
        check("bp_stable", first_word[36:5], out_data);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        target = words_out + 2;
        for (int c = 0; c < 20 && words_out < target; c++) @(posedge clk);
        #1;
        check("bp_words", 32'(words_out), 32'(target));
        repeat (3) @(posedge clk);
        #1;
        check("bp_queue_empty", 32'(expq.size()), 32'd0);

        // Reset in the middle of a word.
        send(16'h3F80, 1'b0);
        send(16'h4040, 1'b0);
        pulse_rst();
        @(negedge clk);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(16'h4040, 1'b0);
        send(16'h3F80, 1'b0);
        send(16'h3F98, 1'b0);
        send(16'h3F80, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("mrst_data", out_data, 32'h383A3844);
        check("mrst_keep", 32'(out_keep), 32'hF);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and clear pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            acc2 = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc2 || !in_valid) begin
                in_valid = ($urandom % 4) != 0;
                in_data  = rnd_bf16();
                in_last  = ($urandom % 6) == 0;
            end
            out_ready = ($urandom % 3) != 0;
            clear     = ($urandom % 60) == 0;
        end
        clear = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50 && in_valid; n++) begin
            @(negedge clk);
            acc2 = in_ready;
            @(posedge clk); #1;
            if (acc2) in_valid = 1'b0;
        end
        check("drain_accept", 32'(in_valid), 32'd0);
        send(rnd_bf16(), 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("drain_queue_empty", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
